// File: rtl/c_pkg.sv
// Shared types and width helpers for the streaming unary/thermometer checker.
package c_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Width of the decoded length field for a W-bit vector.
  function automatic int unsigned len_w(input int unsigned w);
    return $clog2(w);
  endfunction

  // Width of a beat counter for N beats; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/c_stream_beat.sv
// Per-beat classification: presence of ones/zeros, monotonicity, popcount.
module c_stream_beat #(
  parameter int unsigned B = 4
) (
  input  logic [B-1:0]           i_x,
  output logic                   beat_any1,
  output logic                   beat_any0,
  output logic                   beat_mono_n,
  output logic                   beat_mono_c,
  output logic [$clog2(B+1)-1:0] beat_pop1
);

  localparam int unsigned BPW = $clog2(B + 1);

  assign beat_any1 = |i_x;
  assign beat_any0 = ~&i_x;

  // Adjacent-pair scan: any 0->1 (or 1->0) step going up breaks monotonicity.
  if (B == 1) begin : g_one_bit
    assign beat_mono_n = 1'b1;
    assign beat_mono_c = 1'b1;
  end else begin : g_multi_bit
    assign beat_mono_n = ~|(~i_x[B-2:0] &  i_x[B-1:1]);
    assign beat_mono_c = ~|( i_x[B-2:0] & ~i_x[B-1:1]);
  end

  // Population count of ones in the beat.
  always_comb begin
    beat_pop1 = '0;
    for (int unsigned i = 0; i < B; i++) begin
      beat_pop1 = beat_pop1 + BPW'(i_x[i]);
    end
  end

endmodule

// File: rtl/c_stream.sv
// Multi-beat unary/thermometer admission checker with a registered verdict.
module c_stream
  import c_pkg::*;
#(
  parameter int unsigned W                     = 16,
  parameter int unsigned B                     = 4,
  parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_vld,
  input  logic [B-1:0]        i_x,
  output logic                o_rdy,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic                o_is_unary,
  output logic                o_is_compliment,
  output logic [len_w(W)-1:0] o_len
);

  localparam int unsigned N   = W / B;
  localparam int unsigned CW  = cnt_w(N);
  localparam int unsigned LW  = len_w(W);
  localparam int unsigned PW  = $clog2(W + 1);
  localparam int unsigned BPW = $clog2(B + 1);

  if ((W < 2) || (B < 1) || ((W % B) != 0)) begin : g_param_check
    $error("c_stream: W must be >= 2 and a multiple of B");
  end

  logic           beat_any1, beat_any0, beat_mono_n, beat_mono_c;
  logic [BPW-1:0] beat_pop1;

  c_stream_beat #(.B(B)) u_beat (
    .i_x        (i_x),
    .beat_any1  (beat_any1),
    .beat_any0  (beat_any0),
    .beat_mono_n(beat_mono_n),
    .beat_mono_c(beat_mono_c),
    .beat_pop1  (beat_pop1)
  );

  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen0_q, seen0_d, seen1_q, seen1_d;
  logic          bad_n_q, bad_n_d, bad_c_q, bad_c_d;
  logic [PW-1:0] ones_q, ones_d, zeros_q, zeros_d;
  logic          is_unary_q, is_unary_d, is_comp_q, is_comp_d;
  logic [LW-1:0] len_q, len_d;
  state_e        state_q, state_d;

  logic          vld;
  logic          accept, last_beat, fin;
  logic          bad_n_p, bad_c_p, ok_n, ok_c, msb;
  logic [PW-1:0] ones_p, zeros_p;

  assign vld       = (state_q == ST_FULL);
  assign accept    = i_vld & (~vld | i_rdy);
  assign last_beat = (cnt_q == CW'(N - 1));
  assign fin       = accept & last_beat;
  assign msb       = i_x[B-1];

  // Accumulator values including the current beat.
  always_comb begin
    bad_n_p = bad_n_q | ~beat_mono_n | (beat_any1 & seen0_q);
    bad_c_p = bad_c_q | ~beat_mono_c | (beat_any0 & seen1_q);
    ones_p  = ones_q + PW'(beat_pop1);
    zeros_p = zeros_q + PW'(B) - PW'(beat_pop1);
    ok_n    = ~bad_n_p & ~msb;
    ok_c    = P_ADMIT_COMPLIMENT_EN & ~bad_c_p & msb;
  end

  // Counter and accumulator update; final beat clears for the next vector.
  always_comb begin
    cnt_d   = cnt_q;
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    bad_n_d = bad_n_q;
    bad_c_d = bad_c_q;
    ones_d  = ones_q;
    zeros_d = zeros_q;
    if (accept) begin
      if (last_beat) begin
        cnt_d   = '0;
        seen0_d = 1'b0;
        seen1_d = 1'b0;
        bad_n_d = 1'b0;
        bad_c_d = 1'b0;
        ones_d  = '0;
        zeros_d = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        seen0_d = seen0_q | beat_any0;
        seen1_d = seen1_q | beat_any1;
        bad_n_d = bad_n_p;
        bad_c_d = bad_c_p;
        ones_d  = ones_p;
        zeros_d = zeros_p;
      end
    end
  end

  // Verdict loads on the final beat and otherwise holds.
  always_comb begin
    is_unary_d = is_unary_q;
    is_comp_d  = is_comp_q;
    len_d      = len_q;
    if (fin) begin
      is_unary_d = ok_n | ok_c;
      is_comp_d  = P_ADMIT_COMPLIMENT_EN & msb;
      len_d      = ok_n ? LW'(ones_p) : (ok_c ? LW'(zeros_p) : '0);
    end
  end

  // Output FSM next state: FULL reloads when a new verdict lands on a drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (fin) state_d = ST_FULL;
      ST_FULL: begin
        if (fin)        state_d = ST_FULL;
        else if (i_rdy) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      seen0_q    <= 1'b0;
      seen1_q    <= 1'b0;
      bad_n_q    <= 1'b0;
      bad_c_q    <= 1'b0;
      ones_q     <= '0;
      zeros_q    <= '0;
      is_unary_q <= 1'b0;
      is_comp_q  <= 1'b0;
      len_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      seen0_q    <= seen0_d;
      seen1_q    <= seen1_d;
      bad_n_q    <= bad_n_d;
      bad_c_q    <= bad_c_d;
      ones_q     <= ones_d;
      zeros_q    <= zeros_d;
      is_unary_q <= is_unary_d;
      is_comp_q  <= is_comp_d;
      len_q      <= len_d;
    end
  end

  // Output decode from state and verdict registers.
  always_comb begin
    o_vld           = vld;
    o_rdy           = ~vld | i_rdy;
    o_is_unary      = is_unary_q;
    o_is_compliment = is_comp_q;
    o_len           = len_q;
  end

endmodule
